ext_mem_native_slv: RTL and testbench



---
 rtl/ext_mem_native_slv_if.sv | 33 +++
 rtl/ext_mem_native_slv.sv | 175 +++++++++++++++++
 tb/tb_ext_mem_native_slv.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_native_slv_if.sv
// Native register-bus request/ack channel between a regslv ext_* port and an ext target.
// Latency: none (wires only).
// Backpressure: req_vld/req_rdy on the request side, ack_vld/ack_rdy on the response side.
//
// Signals (master drives -> slave):
//   req_vld, wr_en, rd_en, addr, wr_data, ack_rdy
// Signals (slave drives -> master):
//   req_rdy, ack_vld, rd_data, err
interface ext_mem_native_slv_if #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req_vld;
   logic                  req_rdy;
   logic                  wr_en;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  ack_vld;
   logic                  ack_rdy;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  err;

   modport master (
      output req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
      input  req_rdy, ack_vld, rd_data, err
   );

   modport slave (
      input  req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
      output req_rdy, ack_vld, rd_data, err
   );
endinterface

// File: rtl/ext_mem_native_slv.sv
// Flop-based external memory slave: one outstanding word read/write on the native bus.
// Latency: ack_vld rises LATENCY clocks after the request-accept edge.
// Backpressure: req_rdy low from accept until the cycle after the ack handshake; ack held until ack_rdy.
//
// Ports:
//   clk                  clock
//   rstn                 asynchronous active-low reset (clears control state and memory)
//   global_sync_reset_in synchronous reset of control state only; memory retained
//   parity_inj           (EXT_MEM_PARITY_EN only) flips the stored parity bit of a write
//   bus                  ext_mem_native_slv_if.slave request/ack channel
// Optional feature macro: EXT_MEM_PARITY_EN adds a per-word even-parity bit and read-side check.
module ext_mem_native_slv #(
   parameter int unsigned           ADDR_WIDTH = 64,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           DEPTH      = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000,
   parameter int unsigned           LATENCY    = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     global_sync_reset_in,
`ifdef EXT_MEM_PARITY_EN
   input  logic                     parity_inj,
`endif
   ext_mem_native_slv_if.slave      bus
);

   localparam int unsigned           IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned           CNT_W = 3;
   localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH * 4);
   localparam logic [CNT_W-1:0]      LAT_C = CNT_W'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   req_rdy_q;
   logic                   ack_vld_q;
   logic [DATA_WIDTH-1:0]  rd_data_q;
   logic                   err_q;
   logic                   is_rd_q;
   logic                   dec_err_q;
   logic [IDX_W-1:0]       idx_q;
   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
`ifdef EXT_MEM_PARITY_EN
   logic                   par_q [DEPTH];
`endif

   // Request decode, evaluated on the live bus; only used on the accept edge.
   logic [ADDR_WIDTH-1:0]  offs;
   logic                   in_range;
   logic                   ok_wr;
   logic                   ok_rd;
   logic                   req_err;
   logic [IDX_W-1:0]       req_idx;
   logic                   accept;

   always_comb begin
      offs     = bus.addr - BASE_ADDR;
      // addr >= BASE_ADDR guarantees offs did not wrap, so the span compare is safe.
      in_range = (bus.addr >= BASE_ADDR) && (offs < SPAN) && (bus.addr[1:0] == 2'b00);
      ok_wr    = bus.wr_en && !bus.rd_en;
      ok_rd    = bus.rd_en && !bus.wr_en;
      req_err  = !(in_range && (ok_wr || ok_rd));
      req_idx  = offs[IDX_W+1:2];
      accept   = (state_q == S_IDLE) && req_rdy_q && bus.req_vld && !global_sync_reset_in;
   end

   // Response payload sampled on the edge that enters ACK, so any earlier write is visible.
   logic [DATA_WIDTH-1:0]  rd_data_d;
   logic                   err_d;

   always_comb begin
      rd_data_d = '0;
      err_d     = dec_err_q;
      if (!dec_err_q && is_rd_q) begin
         rd_data_d = mem_q[idx_q];
`ifdef EXT_MEM_PARITY_EN
         // Parity fault is reported but the data is still returned.
         if ((^mem_q[idx_q]) != par_q[idx_q]) begin
            err_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         req_rdy_q <= 1'b0;
         ack_vld_q <= 1'b0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
         is_rd_q   <= 1'b0;
         dec_err_q <= 1'b0;
         idx_q     <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
`ifdef EXT_MEM_PARITY_EN
            par_q[i] <= 1'b0;
`endif
         end
      end else if (global_sync_reset_in) begin
         // Drop any pending request without an ack; memory contents stay.
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         req_rdy_q <= 1'b1;
         ack_vld_q <= 1'b0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               req_rdy_q <= 1'b1;
               if (accept) begin
                  req_rdy_q <= 1'b0;
                  is_rd_q   <= ok_rd;
                  dec_err_q <= req_err;
                  idx_q     <= req_idx;
                  // Counter counts accept-relative edges; ACK is entered when it reaches LATENCY.
                  cnt_q     <= CNT_W'(1);
                  state_q   <= S_WAIT;
                  // Writes commit on the accept edge, independent of the ack that follows.
                  if (!req_err && ok_wr) begin
                     mem_q[req_idx] <= bus.wr_data;
`ifdef EXT_MEM_PARITY_EN
                     par_q[req_idx] <= (^bus.wr_data) ^ parity_inj;
`endif
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == LAT_C) begin
                  state_q   <= S_ACK;
                  cnt_q     <= '0;
                  ack_vld_q <= 1'b1;
                  rd_data_q <= rd_data_d;
                  err_q     <= err_d;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_ACK: begin
               if (bus.ack_rdy) begin
                  state_q   <= S_IDLE;
                  ack_vld_q <= 1'b0;
                  rd_data_q <= '0;
                  err_q     <= 1'b0;
                  req_rdy_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               cnt_q     <= '0;
               ack_vld_q <= 1'b0;
               rd_data_q <= '0;
               err_q     <= 1'b0;
               req_rdy_q <= 1'b1;
            end
         endcase
      end
   end

   // rd_data_q/err_q are cleared whenever ack_vld_q drops, so outputs are zero outside an ack.
   assign bus.req_rdy = req_rdy_q;
   assign bus.ack_vld = ack_vld_q;
   assign bus.rd_data = rd_data_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_ext_mem_native_slv.sv
// Bench for ext_mem_native_slv: vector table, corner sequences, randomized traffic vs. word-array model.
module tb_ext_mem_native_slv;
   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 16;
   localparam logic [63:0] BASE  = 64'h1000;

   logic clk;
   logic rstn;
   logic global_sync_reset_in;
   logic parity_inj;

   int n_cmp  = 0;
   int n_fail = 0;

   ext_mem_native_slv_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) bus ();

   ext_mem_native_slv #(
      .ADDR_WIDTH(64), .DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
   ) dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .global_sync_reset_in (global_sync_reset_in),
`ifdef EXT_MEM_PARITY_EN
      .parity_inj           (parity_inj),
`endif
      .bus                  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // Reference model: a plain word array plus the address rules.
   logic [31:0] mdl [DEPTH];

   function automatic logic mdl_ok(input logic [63:0] a, input logic w, input logic r);
      return (a >= BASE) && (a < BASE + 64'(DEPTH) * 4) && (a % 4 == 0) && (w != r);
   endfunction

   function automatic int mdl_idx(input logic [63:0] a);
      return int'((a - BASE) / 4);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // One full transaction. Called right after a posedge (+1).
   task automatic xact(input logic [63:0] a, input logic w, input logic r, input logic [31:0] wd,
                       input logic pinj, input int hold,
                       output logic [31:0] rdat, output logic e);
      int n;
      int lat;
      n = 0;
      while (!bus.req_rdy && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.req_rdy) begin
         check("req_rdy wait timeout", 64'(bus.req_rdy), 64'd1);
         rdat = 'x; e = 1'bx;
         return;
      end
      bus.req_vld = 1'b1; bus.addr = a; bus.wr_en = w; bus.rd_en = r; bus.wr_data = wd;
      parity_inj  = pinj;
      bus.ack_rdy = (hold == 0);
      @(posedge clk); #1;
      // Fields after accept must be ignored.
      bus.req_vld = 1'b0; bus.addr = {$urandom, $urandom}; bus.wr_data = $urandom;
      bus.wr_en = 1'($urandom); bus.rd_en = 1'($urandom); parity_inj = 1'($urandom);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus.ack_vld && lat < 10);
      check("ack latency", 64'(lat), 64'(LAT));
      rdat = bus.rd_data;
      e    = bus.err;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check("hold ack_vld", 64'(bus.ack_vld), 64'd1);
         check("hold rd_data", 64'(bus.rd_data), 64'(rdat));
         check("hold err", 64'(bus.err), 64'(e));
         check("hold req_rdy", 64'(bus.req_rdy), 64'd0);
      end
      bus.ack_rdy = 1'b1;
      @(posedge clk); #1;
      check("post-ack ack_vld", 64'(bus.ack_vld), 64'd0);
      check("post-ack req_rdy", 64'(bus.req_rdy), 64'd1);
      check("post-ack rd_data", 64'(bus.rd_data), 64'd0);
      check("post-ack err", 64'(bus.err), 64'd0);
   endtask

   typedef struct {
      logic [63:0] addr;
      logic        wr;
      logic        rd;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [31:0] d;
      logic        e;
      logic [63:0] a;
      logic        w, r;
      logic [31:0] wd;
      logic        saw_ack;
      int          sel;

      vecs[0]  = '{64'h1008, 1'b1, 1'b0, 32'h12345678, 32'h0,        1'b0};
      vecs[1]  = '{64'h1008, 1'b0, 1'b1, 32'h0,        32'h12345678, 1'b0};
      vecs[2]  = '{64'h1000, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0};
      vecs[3]  = '{64'h0FFC, 1'b1, 1'b0, 32'h11111111, 32'h0,        1'b1};
      vecs[4]  = '{64'h1040, 1'b0, 1'b1, 32'h0,        32'h0,        1'b1};
      vecs[5]  = '{64'h1002, 1'b1, 1'b0, 32'h22222222, 32'h0,        1'b1};
      vecs[6]  = '{64'h1000, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[7]  = '{64'h1004, 1'b0, 1'b0, 32'h33333333, 32'h0,        1'b1};
      vecs[8]  = '{64'h1000, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0};
      vecs[9]  = '{64'h103C, 1'b1, 1'b0, 32'hA1B2C3D4, 32'h0,        1'b0};
      vecs[10] = '{64'h103C, 1'b0, 1'b1, 32'h0,        32'hA1B2C3D4, 1'b0};
      vecs[11] = '{64'h1004, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0};

      for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;

      rstn = 1'b0; global_sync_reset_in = 1'b0; parity_inj = 1'b0;
      bus.req_vld = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      bus.addr = '0; bus.wr_data = '0; bus.ack_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset req_rdy", 64'(bus.req_rdy), 64'd0);
      check("reset ack_vld", 64'(bus.ack_vld), 64'd0);
      check("reset rd_data", 64'(bus.rd_data), 64'd0);
      check("reset err", 64'(bus.err), 64'd0);
      @(negedge clk); rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle req_rdy", 64'(bus.req_rdy), 64'd1);

      // Directed vector table.
      for (int i = 0; i < 12; i++) begin
         xact(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata, 1'b0, 0, d, e);
         check($sformatf("vec%0d rd_data", i), 64'(d), 64'(vecs[i].exp_data));
         check($sformatf("vec%0d err", i), 64'(e), 64'(vecs[i].exp_err));
      end
      mdl[2] = 32'h12345678;
      mdl[15] = 32'hA1B2C3D4;

      // Ack backpressure for 5 cycles.
      xact(64'h1008, 1'b0, 1'b1, 32'h0, 1'b0, 5, d, e);
      check("bp rd_data", 64'(d), 64'h12345678);
      check("bp err", 64'(e), 64'd0);

      // Sync reset while a write is in WAIT: no ack, write already committed.
      bus.req_vld = 1'b1; bus.addr = 64'h100C; bus.wr_en = 1'b1; bus.rd_en = 1'b0;
      bus.wr_data = 32'hDEADBEEF; bus.ack_rdy = 1'b1;
      @(posedge clk); #1;
      bus.req_vld = 1'b0;
      global_sync_reset_in = 1'b1;
      @(posedge clk); #1;
      global_sync_reset_in = 1'b0;
      saw_ack = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (bus.ack_vld) saw_ack = 1'b1;
         @(posedge clk); #1;
      end
      check("gsr no ack", 64'(saw_ack), 64'd0);
      check("gsr idle req_rdy", 64'(bus.req_rdy), 64'd1);
      mdl[3] = 32'hDEADBEEF;
      xact(64'h100C, 1'b0, 1'b1, 32'h0, 1'b0, 0, d, e);
      check("gsr readback", 64'(d), 64'hDEADBEEF);

      // Request presented together with sync reset must not be accepted.
      bus.req_vld = 1'b1; bus.addr = 64'h1010; bus.wr_en = 1'b1; bus.rd_en = 1'b0;
      bus.wr_data = 32'h55AA55AA;
      global_sync_reset_in = 1'b1;
      @(posedge clk); #1;
      bus.req_vld = 1'b0; global_sync_reset_in = 1'b0;
      saw_ack = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (bus.ack_vld) saw_ack = 1'b1;
         @(posedge clk); #1;
      end
      check("gsr+req no ack", 64'(saw_ack), 64'd0);
      xact(64'h1010, 1'b0, 1'b1, 32'h0, 1'b0, 0, d, e);
      check("gsr+req no write", 64'(d), 64'(mdl[4]));

`ifdef EXT_MEM_PARITY_EN
      xact(64'h1004, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 0, d, e);
      xact(64'h1004, 1'b0, 1'b1, 32'h0, 1'b0, 0, d, e);
      check("parity bad rd_data", 64'(d), 64'hA5A5A5A5);
      check("parity bad err", 64'(e), 64'd1);
      xact(64'h1004, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 0, d, e);
      xact(64'h1004, 1'b0, 1'b1, 32'h0, 1'b0, 0, d, e);
      check("parity fixed err", 64'(e), 64'd0);
      check("parity fixed rd_data", 64'(d), 64'hA5A5A5A5);
      mdl[1] = 32'hA5A5A5A5;
`endif

      // Async reset while an ack is held: outputs drop at once, memory clears.
      bus.req_vld = 1'b1; bus.addr = 64'h1008; bus.wr_en = 1'b0; bus.rd_en = 1'b1;
      bus.ack_rdy = 1'b0;
      @(posedge clk); #1;
      bus.req_vld = 1'b0;
      repeat (LAT) @(posedge clk);
      #1;
      check("pre-arst ack_vld", 64'(bus.ack_vld), 64'd1);
      check("pre-arst rd_data", 64'(bus.rd_data), 64'h12345678);
      #2 rstn = 1'b0;
      #1;
      check("arst ack_vld", 64'(bus.ack_vld), 64'd0);
      check("arst rd_data", 64'(bus.rd_data), 64'd0);
      check("arst req_rdy", 64'(bus.req_rdy), 64'd0);
      bus.ack_rdy = 1'b1;
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
      xact(64'h1008, 1'b0, 1'b1, 32'h0, 1'b0, 0, d, e);
      check("arst mem cleared", 64'(d), 64'd0);

      // Randomized traffic against the model.
      for (int t = 0; t < 80; t++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       a = BASE - 64'(4 * $urandom_range(1, 4));
            1:       a = BASE + 64'(DEPTH) * 4 + 64'(4 * $urandom_range(0, 3));
            2:       a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 3));
            default: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
         endcase
         sel = int'($urandom_range(0, 9));
         w  = (sel == 0) || (sel >= 2 && sel <= 5);
         r  = (sel == 0) || (sel >= 6);
         wd = $urandom;
         xact(a, w, r, wd, 1'b0, int'($urandom_range(0, 3)), d, e);
         if (mdl_ok(a, w, r)) begin
            check($sformatf("rnd%0d err", t), 64'(e), 64'd0);
            check($sformatf("rnd%0d rd_data", t), 64'(d), r ? 64'(mdl[mdl_idx(a)]) : 64'd0);
            if (w) mdl[mdl_idx(a)] = wd;
         end else begin
            check($sformatf("rnd%0d err", t), 64'(e), 64'd1);
            check($sformatf("rnd%0d rd_data", t), 64'(d), 64'd0);
         end
      end

      // Final sweep: every word matches the model.
      for (int i = 0; i < int'(DEPTH); i++) begin
         xact(BASE + 64'(4 * i), 1'b0, 1'b1, 32'h0, 1'b0, 0, d, e);
         check($sformatf("sweep%0d", i), 64'(d), 64'(mdl[i]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
